cache_request_arbiter: RTL and testbench
========================================

// Module: cache_request_arbiter
// PURPOSE
//  Two-port front end for the single-port direct-mapped cache subsystem (datapath + control unit).
//  Arbitrates between two requesters (port 0, port 1), then sequences one cache access at a time:
//  latches the winner's address and wrEn, pulses cache_start, waits for cache_done,
//  and returns outData_cache with a one-cycle ack to the winner.
//  Sits between the requesting masters and the cache top.
// PARAMETERS
//  ADDR_W       15  cache address width (matches cache top address bus)
//  DATA_W       32  read data width (matches outData_cache)
//  TIMEOUT_CYC  64  max cycles in WAIT before abort (used only with CACHE_ARB_TIMEOUT_EN)
// PORTS
//  globalclock    in   1       sole clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  req0/req1      in   1       request from port 0/1, held high until ack
//  wrEn0/wrEn1    in   1       write enable of the pending request, stable while req high
//  addr0/addr1    in   ADDR_W  address of the pending request, stable while req high
//  ack0/ack1      out  1       one-cycle completion pulse to port 0/1
//  rdata          out  DATA_W  read data, valid in ack cycle, held until next ack
//  err            out  1       one-cycle abort flag, coincident with ack (timeout)
//  busy           out  1       high in every state except IDLE
//  cache_start    out  1       one-cycle start pulse to cache top
//  cache_wrEn     out  1       latched wrEn of granted request
//  cache_address  out  ADDR_W  latched address of granted request
//  cache_done     in   1       cache completion (level or pulse; first high cycle in WAIT counts)
//  cache_rdata    in   DATA_W  cache outData_cache, sampled in the cycle cache_done is seen
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, last_grant=1 (port 0 wins first tie).
//    All outputs 0: ack*, err, busy, cache_start, cache_wrEn, cache_address, rdata.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req, pick winner and latch addr/wrEn into cache_address/cache_wrEn; go ISSUE.
//    Single req: that port wins.
//    Both req: port != last_grant wins (round-robin); last_grant updated at grant.
//  ISSUE: cache_start=1 for exactly this cycle; go WAIT. cache_done is ignored in ISSUE.
//  WAIT: on the first cycle cache_done=1, capture cache_rdata into rdata; go RESP.
//  RESP: ack of the winner =1 for one cycle; go IDLE.
//  Latency: grant edge to ack = 3 cycles + cache service time; min 4 cycles from req to ack.
//  Back-to-back: a req still high in the cycle after ack counts as a new request.
//    Requesters drop req in the ack cycle to avoid a repeat.
//  Write access: rdata still updated from cache_rdata (don't-care content for the requester).
//  req changes after grant: no effect on the current transaction (inputs latched in IDLE).
//  Only one transaction outstanding; the losing requester waits with req held.
//    Starvation-free: bounded to one transaction by round-robin.
//  Reset mid-transaction: aborts immediately to IDLE; no ack is issued.
//    Requester must re-issue. The cache is reset by its own reset.
// CONFIGURATION
//  CACHE_ARB_TIMEOUT_EN defined:
//    Wrap counter (clog2(TIMEOUT_CYC) bits) cleared on WAIT entry, increments each WAIT cycle.
//    If cache_done is not seen by count TIMEOUT_CYC-1, go RESP with err=1 and rdata=0.
//    If cache_done arrives in the same cycle as expiry, done wins (err=0).
//  Not defined: WAIT lasts until cache_done; err tied 0; no counter logic; port list unchanged.
// STRUCTURE
//  cache_arb_pkg: state encodings IDLE/ISSUE/WAIT/RESP (2-bit localparams); ADDR_W/DATA_W defaults.
//  Sub-module rr_pick2: combinational 2-way round-robin pick (req0, req1, last_grant -> grant).
//  FSM, latches and timeout counter live in cache_request_arbiter.
// TESTING
//  req0 only, addr=15'h0040 wrEn=0, done 5 cyc after start:
//    one cache_start pulse, cache_address=0040, ack0 + rdata=cache_rdata, ack1 never.
//  req0 and req1 together after reset:
//    port 0 served first, then port 1; next simultaneous pair -> port 1 first.
//  req1 held continuously, wrEn1=1, addr=15'h7FFF:
//    repeated transactions, cache_wrEn=1, one ack1 per transaction, busy low 1 cycle between.
//  reset driven low while in WAIT:
//    outputs 0 asynchronously, no ack; after release req0 re-served normally.
//  CACHE_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, cache_done never asserted:
//    ack with err=1 and rdata=0 exactly 8 WAIT cycles after entry.
//  cache_done held high as a level across RESP:
//    exactly one ack; next transaction not completed until a fresh WAIT sees done.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the two-port cache request arbiter.
// Optional WAIT timeout is enabled by defining CACHE_ARB_TIMEOUT_EN.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

endpackage

// File: rtl/cache_request_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// grant is the winning port index; only meaningful when a req is high.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0 & req1):  grant = ~last_grant;
      (req1 & ~req0): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_request_arbiter.sv
// Two-port arbiter sequencing single cache accesses: IDLE/ISSUE/WAIT/RESP.
// Define CACHE_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles.
module cache_request_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wrEn0,
  input  logic              wrEn1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              cache_start,
  output logic              cache_wrEn,
  output logic [ADDR_W-1:0] cache_address,
  input  logic              cache_done,
  input  logic [DATA_W-1:0] cache_rdata
);

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   pick;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge globalclock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      winner        <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      cache_start   <= 1'b0;
      cache_wrEn    <= 1'b0;
      cache_address <= '0;
      rdata         <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      err           <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      cache_start <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
      err         <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner        <= pick;
            last_grant    <= pick;
            cache_address <= pick ? addr1 : addr0;
            cache_wrEn    <= pick ? wrEn1 : wrEn0;
            cache_start   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          // done has priority over an expiring timeout
          if (cache_done) begin
            rdata <= cache_rdata;
            ack0  <= ~winner;
            ack1  <= winner;
            state <= RESP;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (cnt == LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            ack0  <= ~winner;
            ack1  <= winner;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed self-checking bench for cache_request_arbiter.
// Timeout scenarios run only when CACHE_ARB_TIMEOUT_EN is defined.
module tb_cache_request_arbiter;

  logic        globalclock;
  logic        reset;
  logic        req0, req1, wrEn0, wrEn1;
  logic [14:0] addr0, addr1;
  logic        ack0, ack1, err, busy;
  logic [31:0] rdata;
  logic        cache_start, cache_wrEn;
  logic [14:0] cache_address;
  logic        cache_done;
  logic [31:0] cache_rdata;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ack0 = 0;
  int n_ack1 = 0;

  cache_request_arbiter #(
    .ADDR_W(15), .DATA_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .globalclock   (globalclock),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .wrEn0         (wrEn0),
    .wrEn1         (wrEn1),
    .addr0         (addr0),
    .addr1         (addr1),
    .ack0          (ack0),
    .ack1          (ack1),
    .rdata         (rdata),
    .err           (err),
    .busy          (busy),
    .cache_start   (cache_start),
    .cache_wrEn    (cache_wrEn),
    .cache_address (cache_address),
    .cache_done    (cache_done),
    .cache_rdata   (cache_rdata)
  );

  initial begin
    globalclock = 1'b0;
    forever #5 globalclock = ~globalclock;
  end

  always @(negedge globalclock) begin
    if (cache_start) n_start++;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge globalclock);
    #1;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cache_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // called in the ISSUE cycle; returns in the cycle after done is sampled
  task automatic serve(input int dly, input logic [31:0] d);
    cache_rdata = d;
    repeat (dly) step();
    cache_done = 1'b1;
    step();
    cache_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, err, busy, cache_start, cache_wrEn} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000000",
               {ack0, ack1, err, busy, cache_start, cache_wrEn});
    end
    checks++;
    if (cache_address !== 15'h0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=0000", cache_address);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int s0, a1;
    s0 = n_start;
    a1 = n_ack1;
    req0 = 1'b1;
    addr0 = 15'h0040;
    wrEn0 = 1'b0;
    step();
    checks++;
    if ({cache_start, busy, cache_wrEn} !== 3'b110) begin
      errors++;
      $display("FAIL single_issue got=%b exp=110",
               {cache_start, busy, cache_wrEn});
    end
    checks++;
    if (cache_address !== 15'h0040) begin
      errors++;
      $display("FAIL single_addr got=%h exp=0040", cache_address);
    end
    cache_rdata = 32'hCAFE_0040;
    repeat (5) step();
    checks++;
    if (ack0 !== 1'b0 || cache_start !== 1'b0) begin
      errors++;
      $display("FAIL single_wait got=%b%b exp=00", ack0, cache_start);
    end
    cache_done = 1'b1;
    step();
    cache_done = 1'b0;
    checks++;
    if ({ack0, ack1, err} !== 3'b100) begin
      errors++;
      $display("FAIL single_ack got=%b exp=100", {ack0, ack1, err});
    end
    checks++;
    if (rdata !== 32'hCAFE_0040) begin
      errors++;
      $display("FAIL single_rdata got=%h exp=cafe0040", rdata);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got=%b%b exp=00", ack0, busy);
    end
    step();
    checks++;
    if (n_start - s0 !== 1 || n_ack1 - a1 !== 0) begin
      errors++;
      $display("FAIL single_counts starts=%0d ack1=%0d exp=1,0",
               n_start - s0, n_ack1 - a1);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    do_reset();
    addr0 = 15'h0100;
    addr1 = 15'h0200;
    wrEn0 = 1'b0;
    wrEn1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    wait_start(seen);
    checks++;
    if (!seen || cache_address !== 15'h0100) begin
      errors++;
      $display("FAIL rr_first seen=%b addr=%h exp=1,0100",
               seen, cache_address);
    end
    serve(1, 32'h1111_0000);
    checks++;
    if ({ack0, ack1} !== 2'b10 || rdata !== 32'h1111_0000) begin
      errors++;
      $display("FAIL rr_ack_first got=%b %h exp=10 11110000",
               {ack0, ack1}, rdata);
    end
    req0 = 1'b0;
    step();
    req0 = 1'b1;
    step();
    checks++;
    if (cache_start !== 1'b1 || cache_address !== 15'h0200) begin
      errors++;
      $display("FAIL rr_second start=%b addr=%h exp=1,0200",
               cache_start, cache_address);
    end
    serve(1, 32'h2222_0000);
    checks++;
    if ({ack0, ack1} !== 2'b01 || rdata !== 32'h2222_0000) begin
      errors++;
      $display("FAIL rr_ack_second got=%b %h exp=01 22220000",
               {ack0, ack1}, rdata);
    end
    req1 = 1'b0;
    step();
    step();
    checks++;
    if (cache_start !== 1'b1 || cache_address !== 15'h0100) begin
      errors++;
      $display("FAIL rr_third start=%b addr=%h exp=1,0100",
               cache_start, cache_address);
    end
    serve(2, 32'h3333_0000);
    checks++;
    if ({ack0, ack1} !== 2'b10) begin
      errors++;
      $display("FAIL rr_ack_third got=%b exp=10", {ack0, ack1});
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bit seen;
    int a1;
    a1 = n_ack1;
    req1 = 1'b1;
    wrEn1 = 1'b1;
    addr1 = 15'h7FFF;
    for (int k = 0; k < 3; k++) begin
      wait_start(seen);
      checks++;
      if (!seen || cache_wrEn !== 1'b1 || cache_address !== 15'h7FFF) begin
        errors++;
        $display("FAIL b2b_issue%0d seen=%b wr=%b addr=%h exp=1,1,7fff",
                 k, seen, cache_wrEn, cache_address);
      end
      serve(2, 32'hB000_0000 + k);
      checks++;
      if ({ack0, ack1} !== 2'b01 || rdata !== 32'hB000_0000 + k) begin
        errors++;
        $display("FAIL b2b_ack%0d got=%b %h exp=01 %h",
                 k, {ack0, ack1}, rdata, 32'hB000_0000 + k);
      end
      if (k == 2) req1 = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || ack1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d busy=%b ack1=%b exp=0,0", k, busy, ack1);
      end
      if (k < 2) begin
        step();
        checks++;
        if (busy !== 1'b1 || cache_start !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart%0d busy=%b start=%b exp=1,1",
                   k, busy, cache_start);
        end
      end
    end
    step();
    step();
    checks++;
    if (n_ack1 - a1 !== 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count ack1=%0d busy=%b exp=3,0", n_ack1 - a1, busy);
    end
    wrEn1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int a0;
    a0 = n_ack0;
    req0 = 1'b1;
    addr0 = 15'h0123;
    wrEn0 = 1'b1;
    wait_start(seen);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, err, busy, cache_start, cache_wrEn} !== 6'b0) begin
      errors++;
      $display("FAIL rmid_flags got=%b exp=000000",
               {ack0, ack1, err, busy, cache_start, cache_wrEn});
    end
    checks++;
    if (cache_address !== 15'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmid_data addr=%h rdata=%h exp=0,0",
               cache_address, rdata);
    end
    step();
    reset = 1'b1;
    wait_start(seen);
    checks++;
    if (!seen || cache_address !== 15'h0123 || cache_wrEn !== 1'b1) begin
      errors++;
      $display("FAIL rmid_reissue seen=%b addr=%h wr=%b exp=1,0123,1",
               seen, cache_address, cache_wrEn);
    end
    serve(1, 32'h0000_0123);
    checks++;
    if (ack0 !== 1'b1 || rdata !== 32'h0000_0123) begin
      errors++;
      $display("FAIL rmid_ack got=%b %h exp=1 00000123", ack0, rdata);
    end
    req0 = 1'b0;
    wrEn0 = 1'b0;
    step();
    step();
    checks++;
    if (n_ack0 - a0 !== 1) begin
      errors++;
      $display("FAIL rmid_count ack0=%0d exp=1", n_ack0 - a0);
    end
  endtask

  task automatic test_level_done();
    bit seen;
    int a0;
    a0 = n_ack0;
    req0 = 1'b1;
    addr0 = 15'h0ABC;
    wait_start(seen);
    cache_rdata = 32'h1E1E_0001;
    cache_done = 1'b1;
    step();
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL level_issue_ignored ack0=%b exp=0", ack0);
    end
    step();
    checks++;
    if (ack0 !== 1'b1 || rdata !== 32'h1E1E_0001) begin
      errors++;
      $display("FAIL level_ack got=%b %h exp=1 1e1e0001", ack0, rdata);
    end
    req0 = 1'b0;
    step();
    step();
    step();
    checks++;
    if (n_ack0 - a0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL level_single ack0=%0d busy=%b exp=1,0", n_ack0 - a0, busy);
    end
    req1 = 1'b1;
    addr1 = 15'h0DEF;
    cache_rdata = 32'h1E1E_0002;
    step();
    checks++;
    if (cache_start !== 1'b1 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL level_issue2 start=%b ack1=%b exp=1,0", cache_start, ack1);
    end
    step();
    checks++;
    if (ack1 !== 1'b0) begin
      errors++;
      $display("FAIL level_wait2 ack1=%b exp=0", ack1);
    end
    step();
    checks++;
    if (ack1 !== 1'b1 || rdata !== 32'h1E1E_0002) begin
      errors++;
      $display("FAIL level_ack2 got=%b %h exp=1 1e1e0002", ack1, rdata);
    end
    req1 = 1'b0;
    cache_done = 1'b0;
    step();
    step();
  endtask

`ifdef CACHE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    bit early;
    req0 = 1'b1;
    addr0 = 15'h0055;
    cache_done = 1'b0;
    wait_start(seen);
    step();
    early = 1'b0;
    repeat (7) begin
      step();
      if (ack0 || err) early = 1'b1;
    end
    checks++;
    if (!seen || early) begin
      errors++;
      $display("FAIL tmo_early seen=%b early=%b exp=1,0", seen, early);
    end
    step();
    checks++;
    if ({ack0, err} !== 2'b11 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_abort got=%b %h exp=11 0", {ack0, err}, rdata);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_pulse err=%b exp=0", err);
    end
    req0 = 1'b1;
    cache_rdata = 32'h7777_0008;
    wait_start(seen);
    step();
    repeat (6) step();
    cache_done = 1'b1;
    step();
    cache_done = 1'b0;
    checks++;
    if ({ack0, err} !== 2'b10 || rdata !== 32'h7777_0008) begin
      errors++;
      $display("FAIL tmo_done_wins got=%b %h exp=10 77770008",
               {ack0, err}, rdata);
    end
    req0 = 1'b0;
    step();
  endtask
`endif

  initial begin
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    wrEn0 = 1'b0;
    wrEn1 = 1'b0;
    addr0 = '0;
    addr1 = '0;
    cache_done = 1'b0;
    cache_rdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_level_done();
`ifdef CACHE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
